// File: rtl/bulk_line_word_bridge.sv
// Bridges whole-line cache requests onto a word-wide memory port, one word in flight at a time.
// Reads are gathered into a full line and returned with a one-cycle pulse; writes drain silently.
module bulk_line_word_bridge #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int OFFSET_BITS = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic [ADDR_W-1:0]                i_req_addr,
    input  logic                             i_req_write,
    input  logic [(1<<OFFSET_BITS)*8-1:0]    i_req_wdata,
    input  logic [(1<<OFFSET_BITS)-1:0]      i_req_wstrb,
    output logic                             o_resp_valid,
    output logic [(1<<OFFSET_BITS)*8-1:0]    o_resp_rdata,
    input  logic                             i_dumping_cache,
    output logic                             o_mem_req_valid,
    input  logic                             i_mem_req_ready,
    output logic [ADDR_W-1:0]                o_mem_addr,
    output logic                             o_mem_we,
    output logic [DATA_W-1:0]                o_mem_wdata,
    output logic [DATA_W/8-1:0]              o_mem_wstrb,
    input  logic                             i_mem_resp_valid,
    input  logic [DATA_W-1:0]                i_mem_rdata,
    output logic                             o_busy,
    output logic [15:0]                      o_dump_lines
);

    localparam int LINE_BYTES     = 1 << OFFSET_BITS;
    localparam int LINE_W         = LINE_BYTES * 8;
    localparam int WORD_BYTES     = DATA_W / 8;
    localparam int WORDS_PER_LINE = LINE_BYTES / WORD_BYTES;
    localparam int K_W            = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [K_W-1:0]          r_k;
    logic [ADDR_W-1:0]       r_base;
    logic                    r_write;
    logic [LINE_W-1:0]       r_wdata;
    logic [LINE_BYTES-1:0]   r_wstrb;
    logic [LINE_W-1:0]       r_line;
    logic [LINE_W-1:0]       r_resp_rdata;
    logic [15:0]             r_dump_lines;
    logic                    r_dump_prev;

    logic                    w_issue;
    logic                    w_last;
    logic                    w_word_done;
    logic                    w_write_done;
    logic                    w_dump_rise;
    logic [DATA_W-1:0]       w_word_wdata;
    logic [WORD_BYTES-1:0]   w_word_wstrb;
    logic [LINE_W-1:0]       w_line_next;

    assign w_issue      = (r_state == S_ISSUE);
    assign w_last       = (r_k == K_LAST);
    assign w_word_done  = (r_state == S_WAIT) && i_mem_resp_valid;
    assign w_write_done = w_word_done && w_last && r_write;
    assign w_dump_rise  = i_dumping_cache && !r_dump_prev;
    assign w_word_wdata = r_wdata[int'(r_k)*DATA_W +: DATA_W];
    assign w_word_wstrb = r_wstrb[int'(r_k)*WORD_BYTES +: WORD_BYTES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        o_req_ready     = 1'b0;
        o_mem_req_valid = 1'b0;
        o_resp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_resp_valid) begin
                    if (!w_last) begin
                        w_next = S_ISSUE;
                    end else if (r_write) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_RESP;
                    end
                end
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The assembly buffer with the arriving word merged in, so the final word lands in the response too.
    always_comb begin
        w_line_next = r_line;
        w_line_next[int'(r_k)*DATA_W +: DATA_W] = i_mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k          <= '0;
            r_base       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_line       <= '0;
            r_resp_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && i_req_valid) begin
                r_k     <= '0;
                r_base  <= i_req_addr & LINE_MASK;
                r_write <= i_req_write;
                r_wdata <= i_req_wdata;
                r_wstrb <= i_req_wstrb;
            end
            if (w_word_done) begin
                if (!r_write) begin
                    r_line <= w_line_next;
                end
                if (!w_last) begin
                    r_k <= r_k + 1'b1;
                end else if (!r_write) begin
                    r_resp_rdata <= w_line_next;
                end
            end
        end
    end

    // A fresh dump restarts the count; the clear takes priority over a coinciding completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dump_prev  <= 1'b0;
            r_dump_lines <= '0;
        end else begin
            r_dump_prev <= i_dumping_cache;
            if (w_dump_rise) begin
                r_dump_lines <= '0;
            end else if (w_write_done && i_dumping_cache && r_dump_lines != 16'hFFFF) begin
                r_dump_lines <= r_dump_lines + 16'd1;
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_resp_rdata = r_resp_rdata;
    assign o_dump_lines = r_dump_lines;
    assign o_mem_addr   = w_issue ? (r_base + ADDR_W'(r_k) * ADDR_W'(WORD_BYTES)) : '0;
    assign o_mem_we     = w_issue && r_write;
    assign o_mem_wdata  = (w_issue && r_write) ? w_word_wdata : '0;
    assign o_mem_wstrb  = (w_issue && r_write) ? w_word_wstrb : '0;

endmodule

// File: doc/bulk_line_word_bridge.md
Name: bulk_line_word_bridge

Overview:
- Sits directly downstream of the BRAM line cache, as the slave on its bulk line-request port.
- Converts each whole-line request into a sequence of single-word transactions on a word-wide memory port (main-memory or BRAM controller), one outstanding word at a time.
- Line reads are assembled and returned as one full line with a single-cycle resp_valid; line writes (writebacks/dumps) are accepted and drained with no line-level response.

Parameters:
- ADDR_W, 64, byte address width.
- DATA_W, 64, word width on the memory port; must be a multiple of 8.
- OFFSET_BITS, 7, log2 of line bytes (LINE_BYTES = 128).
- WORDS_PER_LINE, derived, LINE_BYTES/(DATA_W/8) (16 at defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  line request valid.
- req_ready  out  1  line request accept; handshake when req_valid && req_ready.
- req_addr  in  ADDR_W  line base address; low OFFSET_BITS are ignored and treated as 0.
- req_write  in  1  1 = line write, 0 = line read.
- req_wdata  in  LINE_BYTES*8  line data; word i at [i*DATA_W +: DATA_W].
- req_wstrb  in  LINE_BYTES  byte strobes; word i strobes at [i*DATA_W/8 +: DATA_W/8].
- resp_valid  out  1  one-cycle pulse: read line ready.
- resp_rdata  out  LINE_BYTES*8  assembled read line; same packing as req_wdata.
- dumping_cache  in  1  cache dump-in-progress flag.
- mem_req_valid  out  1  word request valid.
- mem_req_ready  in  1  word request accept.
- mem_addr  out  ADDR_W  word byte address.
- mem_we  out  1  word write.
- mem_wdata  out  DATA_W  word write data.
- mem_wstrb  out  DATA_W/8  word byte strobes.
- mem_resp_valid  in  1  word completion (read data or write ack).
- mem_rdata  in  DATA_W  word read data.
- busy  out  1  not in IDLE.
- dump_lines  out  16  write lines completed during the current dump.

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
  - All state returns to IDLE and the word counter clears.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, mem_req_valid=0, mem_addr=0, mem_we=0, mem_wdata=0, mem_wstrb=0, busy=0, dump_lines=0.
  - Reset mid-transfer abandons the transfer with no response. A late mem_resp_valid arriving after reset is ignored, because the block is in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1 and is combinational on state only; it must not depend on req_valid.
  - On handshake, latch base address (low bits zeroed), req_write, req_wdata and req_wstrb; set word index k=0; go to ISSUE.
- ISSUE:
  - mem_req_valid=1, mem_addr = base + k*(DATA_W/8), mem_we = latched write flag.
  - For writes, mem_wdata and mem_wstrb come from word k; for reads, mem_wstrb=0.
  - mem_req_valid stays high, with stable fields, until mem_req_ready. Then go to WAIT.
  - Every word is issued, including words whose strobes are all zero.
- WAIT:
  - On mem_resp_valid: for a read, store mem_rdata into line word k.
  - If k==WORDS_PER_LINE-1, go to RESP for a read or IDLE for a write; otherwise k++ and go to ISSUE.
  - mem_resp_valid is ignored in any other state.
- RESP (reads only): resp_valid=1 for exactly one cycle with the full line, then go to IDLE.
  - No ready on the response; the cache is always waiting.
  - resp_rdata holds its value until the next read completes.
- Latency:
  - Per word: 1 issue cycle (minimum) plus memory latency.
  - Line read with 1-cycle mem_req_ready and a next-cycle mem_resp_valid: req handshake at T0, resp_valid at T0 + 2*WORDS_PER_LINE + 1.
  - A new request can be accepted in the cycle the block returns to IDLE.
- Only one line is in flight. req_ready=0 outside IDLE; a back-to-back request waits.
- The counter k is $clog2(WORDS_PER_LINE) bits wide and never wraps past the last word.
- dump_lines:
  - Increments by 1 (saturating at 0xFFFF) when a write line completes while dumping_cache=1.
  - Clears to 0 on the cycle dumping_cache rises (registered 0->1 edge). If a completion coincides with the rising edge, clear wins and the value becomes 0.
- busy = (state != IDLE).

Test Plan:
- Line read at req_addr=0x1000_0047, memory returning word i = 0xA5A5_0000_0000_0000 | i, mem_req_ready always 1, 1-cycle response -> 16 word reads at 0x1000_0000, 0x1000_0008 ... 0x1000_0078; one resp_valid pulse at T0+33; word 15 of resp_rdata = 0xA5A5_0000_0000_000F.
- Line write at 0x2000_0080 with strobes all-ones except word 3 = 0x0F -> 16 writes in order, mem_wstrb=0xFF except 0x0F at 0x2000_0098; resp_valid never asserts; req_ready=1 again after the last ack.
- mem_req_ready held low for 5 cycles on word 7 -> mem_req_valid, mem_addr and mem_wdata stable throughout; no word skipped or duplicated.
- Request presented while busy (req_valid held) -> req_ready=0 until the prior line finishes, then the second request is accepted in the IDLE cycle and served correctly.
- dumping_cache raised, then 3 write lines -> dump_lines=3; dumping_cache dropped and raised again -> dump_lines=0.
- rst asserted in WAIT on word 9 of a read, followed by a stray mem_resp_valid -> all outputs return to reset values; no resp_valid; the next read completes correctly.
